// File: rtl/alu_pkg.sv
// Shared opcode encoding and width default for the ALU slice.
// The opcode values are the 4-bit sel encoding seen at the alu_32 port.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_ROR  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: decodes sel and produces the next result and carry.
// All 16 encodings are decoded explicitly; carry is 0 unless an operation defines it.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry_next
);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_div0;
    logic [WIDTH-1:0]   w_quot;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow (set exactly when a < b).
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_div0 = (b == '0);
    assign w_quot = w_div0 ? '1 : (a / b);

    always_comb begin
        result     = '0;
        carry_next = 1'b0;
        case (alu_op_e'(sel))
            OP_ADD: begin
                result     = w_sum[WIDTH-1:0];
                carry_next = w_sum[WIDTH];
            end
            OP_SUB: begin
                result     = w_diff[WIDTH-1:0];
                carry_next = w_diff[WIDTH];
            end
            OP_MUL: begin
                result     = w_prod[WIDTH-1:0];
                carry_next = |w_prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                result     = w_quot;
                carry_next = w_div0;
            end
            OP_SHL: begin
                result     = {a[WIDTH-2:0], 1'b0};
                carry_next = a[WIDTH-1];
            end
            OP_SHR: begin
                result     = {1'b0, a[WIDTH-1:1]};
                carry_next = a[0];
            end
            OP_ROL:  result = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  result = {a[0], a[WIDTH-1:1]};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XNOR: result = ~(a ^ b);
            OP_GT:   result = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: begin
                result     = '0;
                carry_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_32.sv
// Single-cycle registered ALU: alu_core feeds one output register stage.
// Reset clears the register asynchronously, so no pending result survives it.
module alu_32
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a          (a),
        .b          (b),
        .sel        (sel),
        .result     (w_result),
        .carry_next (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_out   <= w_result;
            r_carry <= w_carry;
        end
    end

    assign out   = r_out;
    assign carry = r_carry;

endmodule

// File: tb/tb_alu_32.sv
// Scoreboard bench for alu_32: expectations queued at drive time, checked one cycle later.
// Inputs change on the falling edge; outputs are sampled on the falling edge after capture.
module tb_alu_32;

    typedef struct {
        logic [31:0] o;
        logic        c;
        int          idx;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] out;
    logic        carry;

    exp_t sb_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    alu_32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .out   (out),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference built on 64-bit arithmetic.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] s);
        exp_t        m;
        logic [63:0] p;
        m.o = 32'h0; m.c = 1'b0; m.idx = 0;
        p = 64'(x) * 64'(y);
        case (s)
            4'h0: {m.c, m.o} = 33'(x) + 33'(y);
            4'h1: begin m.o = x - y; m.c = (x < y); end
            4'h2: begin m.o = p[31:0]; m.c = (p >= 64'h1_0000_0000); end
            4'h3: begin m.o = (y == 0) ? 32'hFFFF_FFFF : x / y; m.c = (y == 0); end
            4'h4: begin m.o = x << 1; m.c = x[31]; end
            4'h5: begin m.o = x >> 1; m.c = x[0]; end
            4'h6: m.o = (x << 1) | (x >> 31);
            4'h7: m.o = (x >> 1) | (x << 31);
            4'h8: m.o = x & y;
            4'h9: m.o = x | y;
            4'hA: m.o = x ^ y;
            4'hB: m.o = ~(x | y);
            4'hC: m.o = ~(x & y);
            4'hD: m.o = ~(x ^ y);
            4'hE: m.o = (x > y) ? 32'd1 : 32'd0;
            default: m.o = (x == y) ? 32'd1 : 32'd0;
        endcase
        return m;
    endfunction

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [3:0] s,
                         input logic [31:0] eo, input logic ec, input int idx);
        exp_t e;
        a = x; b = y; sel = s;
        e.o = eo; e.c = ec; e.idx = idx;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a = 32'h1A; b = 32'hB2; sel = 4'h0;
        #1;
        vec_cnt++;
        if (out !== 32'h0 || carry !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_async: out=%h carry=%b, expected out=00000000 carry=0", out, carry);
        end
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (out !== 32'h0 || carry !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_hold: out=%h carry=%b, expected out=00000000 carry=0", out, carry);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (out !== 32'hCC || carry !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_first_edge: out=%h carry=%b, expected out=000000cc carry=0", out, carry);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] eo [16] = '{32'hCC, 32'hFFFF_FF68, 32'h1214, 32'h0,
                                 32'h34, 32'hD, 32'h34, 32'hD,
                                 32'h12, 32'hBA, 32'hA8, 32'hFFFF_FF45,
                                 32'hFFFF_FFED, 32'hFFFF_FF57, 32'h0, 32'h0};
        logic [15:0] ec = 16'h0002;
        exp_t e;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                vec_cnt++;
                if (out !== e.o || carry !== e.c) begin
                    err_cnt++;
                    $display("FAIL sweep[%0d]: out=%h carry=%b, expected out=%h carry=%b",
                             e.idx, out, carry, e.o, e.c);
                end
            end
            if (i < 16) drive(32'h1A, 32'hB2, 4'(i), eo[i], ec[i], i);
        end
    endtask

    task automatic test_operands();
        logic [31:0] va [7] = '{32'hF6, 32'hF6, 32'hF6, 32'h5, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        logic [31:0] vb [7] = '{32'h0A, 32'h0A, 32'h0A, 32'h0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        logic [3:0]  vs [7] = '{4'h3, 4'hE, 4'h1, 4'h3, 4'hF, 4'hD, 4'hA};
        logic [31:0] eo [7] = '{32'h18, 32'h1, 32'hEC, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0};
        logic [6:0]  ec = 7'b000_1000;
        exp_t e;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                vec_cnt++;
                if (out !== e.o || carry !== e.c) begin
                    err_cnt++;
                    $display("FAIL operands[%0d]: out=%h carry=%b, expected out=%h carry=%b",
                             e.idx, out, carry, e.o, e.c);
                end
            end
            if (i < 7) drive(va[i], vb[i], vs[i], eo[i], ec[i], i);
        end
    endtask

    task automatic test_carry_boundaries();
        logic [31:0] va [7] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 32'h0001_0000,
                                32'h8000_0001, 32'h8000_0001, 32'h0};
        logic [31:0] vb [7] = '{32'h1, 32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h1};
        logic [3:0]  vs [7] = '{4'h0, 4'h6, 4'h7, 4'h2, 4'h4, 4'h5, 4'h1};
        logic [31:0] eo [7] = '{32'h0, 32'h3, 32'hC000_0000, 32'h0, 32'h2, 32'h4000_0000, 32'hFFFF_FFFF};
        logic [6:0]  ec = 7'b111_1001;
        exp_t e;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                vec_cnt++;
                if (out !== e.o || carry !== e.c) begin
                    err_cnt++;
                    $display("FAIL carry_bound[%0d]: out=%h carry=%b, expected out=%h carry=%b",
                             e.idx, out, carry, e.o, e.c);
                end
            end
            if (i < 7) drive(va[i], vb[i], vs[i], eo[i], ec[i], i);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        exp_t        m;
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  s;
        for (int i = 0; i <= 48; i++) begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                vec_cnt++;
                if (out !== e.o || carry !== e.c) begin
                    err_cnt++;
                    $display("FAIL random[%0d]: out=%h carry=%b, expected out=%h carry=%b",
                             e.idx, out, carry, e.o, e.c);
                end
            end
            if (i < 48) begin
                x = $urandom();
                y = (i % 8 == 7) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(300, 1)) : $urandom());
                if (i % 5 == 0) y = x;
                s = 4'(i % 16);
                m = model(x, y, s);
                drive(x, y, s, m.o, m.c, i);
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        a = 32'h1; b = 32'h2; sel = 4'h1;
        @(negedge clk);
        vec_cnt++;
        if (out !== 32'hFFFF_FFFF || carry !== 1'b1) begin
            err_cnt++;
            $display("FAIL midrst_pre: out=%h carry=%b, expected out=ffffffff carry=1", out, carry);
        end
        a = 32'hF6; b = 32'h0A; sel = 4'h3;
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (out !== 32'h0 || carry !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrst_async: out=%h carry=%b, expected out=00000000 carry=0", out, carry);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (out !== 32'h18 || carry !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrst_release: out=%h carry=%b, expected out=00000018 carry=0", out, carry);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_operands();
        test_carry_boundaries();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
